// File: rtl/full_add_3b_bist_pkg.sv
// Shared definitions for the full_add_3b exhaustive self-test block:
// FSM state encoding and vector/counter width helpers.
package full_add_3b_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_APPLY  = 3'd1,
        S_SETTLE = 3'd2,
        S_CHECK  = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    // Vector index {cin,b,a} width
    function automatic int idx_w(input int width);
        return 2 * width + 1;
    endfunction

    // Error counter width: one bit wider than the index so 2^IDX_W fits
    function automatic int cnt_w(input int width);
        return 2 * width + 2;
    endfunction

endpackage

// File: rtl/full_add_3b_bist_ref.sv
// Golden ripple-carry adder model (combinational), reusable by benches.
// exp_cout[i] is the carry out of bit i; cin feeds bit 0.
module full_add_ref #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] exp_sum,
    output logic [WIDTH-1:0] exp_cout
);

    // Ripple the carry from bit 0 upward
    always_comb begin : ref_chain
        logic c;
        c        = cin;
        exp_sum  = {WIDTH{1'b0}};
        exp_cout = {WIDTH{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            exp_sum[i]  = a[i] ^ b[i] ^ c;
            exp_cout[i] = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
            c           = exp_cout[i];
        end
    end

endmodule

// File: rtl/full_add_3b_bist.sv
// Exhaustive on-board self-test for full_add_3b: walks every {cin,b,a} vector,
// compares the adder's sum/carry vector to a reference and records the outcome.
module full_add_3b_bist
    import full_add_3b_bist_pkg::*;
#(
    parameter int WIDTH         = 3,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic [WIDTH-1:0]   a_o,
    output logic [WIDTH-1:0]   b_o,
    output logic               cin_o,
    input  logic [WIDTH-1:0]   sum_i,
    input  logic [WIDTH-1:0]   cout_i,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [2*WIDTH+1:0] err_cnt,
    output logic [2*WIDTH:0]   first_err_idx,
    output logic               first_err_valid
);

    localparam int IDX_W = idx_w(WIDTH);
    localparam int CNT_W = cnt_w(WIDTH);
    localparam int SC_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [SC_W-1:0]  SC_LOAD = SC_W'(SETTLE_CYCLES - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] r_first_idx;
    logic             r_first_valid;
    logic [CNT_W-1:0] r_err_cnt;
    logic [SC_W-1:0]  r_settle;
    logic             r_busy;
    logic             r_done;
    logic             r_pass;
    logic             w_busy;
    logic             w_done;
    logic [WIDTH-1:0] w_exp_sum;
    logic [WIDTH-1:0] w_exp_cout;
    logic             w_mismatch;

    full_add_ref #(.WIDTH(WIDTH)) u_ref (
        .a        (r_idx[WIDTH-1:0]),
        .b        (r_idx[2*WIDTH-1:WIDTH]),
        .cin      (r_idx[2*WIDTH]),
        .exp_sum  (w_exp_sum),
        .exp_cout (w_exp_cout)
    );

    assign w_mismatch = (sum_i != w_exp_sum) || (cout_i != w_exp_cout);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = S_APPLY; else w_state_nxt = S_IDLE;
            S_APPLY:  w_state_nxt = S_SETTLE;
            S_SETTLE: if (r_settle == {SC_W{1'b0}}) w_state_nxt = S_CHECK;
                      else w_state_nxt = S_SETTLE;
            S_CHECK:  if (r_idx == IDX_MAX) w_state_nxt = S_DONE;
                      else w_state_nxt = S_APPLY;
            S_DONE:   if (start) w_state_nxt = S_APPLY; else w_state_nxt = S_DONE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    // Status decode from the current state
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_APPLY, S_SETTLE, S_CHECK: w_busy = 1'b1;
            S_DONE:                     w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // Vector index, settle timer, error counter and first-failure capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx         <= {IDX_W{1'b0}};
            r_settle      <= {SC_W{1'b0}};
            r_err_cnt     <= {CNT_W{1'b0}};
            r_first_idx   <= {IDX_W{1'b0}};
            r_first_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_idx         <= {IDX_W{1'b0}};
                        r_err_cnt     <= {CNT_W{1'b0}};
                        r_first_idx   <= {IDX_W{1'b0}};
                        r_first_valid <= 1'b0;
                    end
                end
                S_APPLY:  r_settle <= SC_LOAD;
                S_SETTLE: begin
                    if (r_settle != {SC_W{1'b0}}) r_settle <= r_settle - SC_W'(1);
                end
                S_CHECK: begin
                    if (w_mismatch) begin
                        if (r_err_cnt != CNT_MAX) r_err_cnt <= r_err_cnt + CNT_W'(1);
                        if (!r_first_valid) begin
                            r_first_idx   <= r_idx;
                            r_first_valid <= 1'b1;
                        end
                    end
                    // Index holds at max after the last vector
                    if (r_idx != IDX_MAX) r_idx <= r_idx + IDX_W'(1);
                end
                default: r_settle <= {SC_W{1'b0}};
            endcase
        end
    end

    // Registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
        end else begin
            r_busy <= w_busy;
            r_done <= w_done;
            r_pass <= w_done && (r_err_cnt == {CNT_W{1'b0}});
        end
    end

    assign a_o             = r_idx[WIDTH-1:0];
    assign b_o             = r_idx[2*WIDTH-1:WIDTH];
    assign cin_o           = r_idx[2*WIDTH];
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_pass;
    assign err_cnt         = r_err_cnt;
    assign first_err_idx   = r_first_idx;
    assign first_err_valid = r_first_valid;

endmodule

// File: tb/tb_full_add_3b_bist.sv
// Bench for full_add_3b_bist: models the adder (with optional stuck-at faults)
// and checks run results through a queue of expected outcomes.
module tb_full_add_3b_bist;

    localparam int LAT = 1 + 128 * 3;

    typedef struct {
        logic       pass;
        logic [7:0] err;
        logic [6:0] fidx;
        logic       fval;
        int         lat;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic [2:0] a_o;
    logic [2:0] b_o;
    logic       cin_o;
    logic [2:0] sum_i;
    logic [2:0] cout_i;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err_cnt;
    logic [6:0] first_err_idx;
    logic       first_err_valid;

    int   checks;
    int   errors;
    int   fault_mode;
    int   edge_cnt;
    int   run_t0;
    logic [6:0] last_vec;
    exp_t sb_q[$];

    full_add_3b_bist #(.WIDTH(3), .SETTLE_CYCLES(1)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .a_o             (a_o),
        .b_o             (b_o),
        .cin_o           (cin_o),
        .sum_i           (sum_i),
        .cout_i          (cout_i),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_cnt         (err_cnt),
        .first_err_idx   (first_err_idx),
        .first_err_valid (first_err_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Adder model by integer addition: returns {cout, sum}; fault 1 = sum[1] sa0, 2 = cout[2] sa0
    function automatic logic [5:0] adder_model(input logic [2:0] a, input logic [2:0] b,
                                               input logic cin, input int fault);
        logic [3:0] t;
        logic [2:0] m;
        logic [5:0] r;
        t      = {1'b0, a} + {1'b0, b} + {3'b000, cin};
        r      = 6'd0;
        r[2:0] = t[2:0];
        for (int i = 0; i < 3; i++) begin
            m        = 3'((4'd2 << i) - 4'd1);
            t        = {1'b0, a & m} + {1'b0, b & m} + {3'b000, cin};
            r[3 + i] = t[i + 1];
        end
        if (fault == 1) r[1] = 1'b0;
        if (fault == 2) r[5] = 1'b0;
        return r;
    endfunction

    assign {cout_i, sum_i} = adder_model(a_o, b_o, cin_o, fault_mode);

    task automatic push_expected(input int fault);
        exp_t e;
        logic [6:0] v;
        int cnt;
        e.fval = 1'b0;
        e.fidx = 7'd0;
        cnt    = 0;
        for (int k = 0; k < 128; k++) begin
            v = 7'(k);
            if (adder_model(v[2:0], v[5:3], v[6], 0) != adder_model(v[2:0], v[5:3], v[6], fault)) begin
                cnt++;
                if (!e.fval) begin
                    e.fval = 1'b1;
                    e.fidx = v;
                end
            end
        end
        e.err  = 8'(cnt);
        e.pass = (cnt == 0);
        e.lat  = LAT;
        sb_q.push_back(e);
    endtask

    task automatic start_run(input int fault, input int hold);
        fault_mode = fault;
        @(negedge clk);
        start    = 1'b1;
        run_t0   = edge_cnt;
        last_vec = 7'd0;
        repeat (hold) @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_and_check(input string name, input int pulse_at);
        exp_t e;
        logic [6:0] cur;
        int lat;
        bit seen;
        seen = 1'b0;
        lat  = -1;
        for (int k = 0; k < 1000 && !seen; k++) begin
            @(negedge clk);
            start = (pulse_at >= 0) && ((edge_cnt - run_t0 - 1) == pulse_at);
            if (busy) begin
                cur = {cin_o, b_o, a_o};
                if (cur != last_vec) begin
                    checks++;
                    if (cur != 7'(last_vec + 7'd1)) begin
                        errors++;
                        $display("FAIL %s vec_seq: got %0d expected %0d", name, cur, last_vec + 7'd1);
                    end
                    last_vec = cur;
                end
            end
            if (done) begin
                seen = 1'b1;
                lat  = edge_cnt - run_t0 - 1;
            end
        end
        start = 1'b0;
        e = sb_q.pop_front();
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s done_timeout: done never rose, expected at cycle %0d", name, e.lat);
        end else if (lat !== e.lat) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, e.lat);
        end
        checks++;
        if (pass !== e.pass) begin
            errors++;
            $display("FAIL %s pass: got %b expected %b", name, pass, e.pass);
        end
        checks++;
        if (err_cnt !== e.err) begin
            errors++;
            $display("FAIL %s err_cnt: got %0d expected %0d", name, err_cnt, e.err);
        end
        checks++;
        if (first_err_valid !== e.fval) begin
            errors++;
            $display("FAIL %s first_err_valid: got %b expected %b", name, first_err_valid, e.fval);
        end
        if (e.fval) begin
            checks++;
            if (first_err_idx !== e.fidx) begin
                errors++;
                $display("FAIL %s first_err_idx: got %0d expected %0d", name, first_err_idx, e.fidx);
            end
        end
        checks++;
        if (busy !== 1'b0 || last_vec !== 7'd127) begin
            errors++;
            $display("FAIL %s end_state: busy=%b last_vec=%0d expected busy=0 last_vec=127", name, busy, last_vec);
        end
    endtask

    task automatic check_cleared(input string name);
        checks++;
        if ({busy, done, pass, first_err_valid} !== 4'b0000 || err_cnt !== 8'd0 ||
            first_err_idx !== 7'd0 || {cin_o, b_o, a_o} !== 7'd0) begin
            errors++;
            $display("FAIL %s cleared: busy=%b done=%b pass=%b fev=%b err=%0d fidx=%0d vec=%0d expected all 0",
                     name, busy, done, pass, first_err_valid, err_cnt, first_err_idx, {cin_o, b_o, a_o});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_cleared("reset_held");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("reset_idle");
    endtask

    task automatic test_good_run();
        push_expected(0);
        start_run(0, 1);
        wait_and_check("good_run", -1);
    endtask

    task automatic test_sum_fault();
        push_expected(1);
        start_run(1, 1);
        wait_and_check("sum1_sa0", -1);
    endtask

    task automatic test_cout_fault();
        push_expected(2);
        start_run(2, 1);
        wait_and_check("cout2_sa0", -1);
    endtask

    task automatic test_reset_mid_run();
        start_run(1, 1);
        while ((edge_cnt - run_t0 - 1) < 100) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || err_cnt === 8'd0) begin
            errors++;
            $display("FAIL mid_run_pre: busy=%b err_cnt=%0d expected busy=1 err_cnt>0", busy, err_cnt);
        end
        rst = 1'b1;
        #1;
        check_cleared("mid_run_async");
        @(negedge clk);
        check_cleared("mid_run_next_edge");
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_cleared("mid_run_idle");
        push_expected(0);
        start_run(0, 1);
        wait_and_check("after_reset_run", -1);
    endtask

    task automatic test_start_while_busy();
        push_expected(0);
        start_run(0, 1);
        wait_and_check("start_busy", 50);
    endtask

    task automatic test_restart_from_done();
        // Previous run left done=1 with a nonzero error count
        push_expected(0);
        start_run(0, 3);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || err_cnt !== 8'd0 || first_err_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart: done=%b busy=%b err_cnt=%0d fev=%b expected 0 1 0 0",
                     done, busy, err_cnt, first_err_valid);
        end
        wait_and_check("restart_run", -1);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        fault_mode = 0;
        edge_cnt   = 0;
        run_t0     = 0;
        last_vec   = 7'd0;
        rst        = 1'b1;
        start      = 1'b0;
        test_reset();
        test_good_run();
        test_sum_fault();
        test_cout_fault();
        test_reset_mid_run();
        test_start_while_busy();
        test_sum_fault();
        test_restart_from_done();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
